// File: rtl/gate_2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gate_2_pkg : shared constants and types for the gate_2 gate bank |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
package gate_2_pkg;

  localparam int Z_AND  = 0;
  localparam int Z_NAND = 1;
  localparam int Z_OR   = 2;
  localparam int Z_NOR  = 3;
  localparam int Z_XOR  = 4;
  localparam int Z_XNOR = 5;
  localparam int Z_W    = 6;

  typedef logic [Z_W-1:0] gate_vec_t;

  // The a=0/b=0 row, so the reset value is itself a legal truth-table row.
  localparam gate_vec_t Z_RESET = 6'h2A;

endpackage
`default_nettype wire

// File: rtl/gate_2_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gate_2_if : operand inputs and gate-result bus of gate_2         |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
interface gate_2_if;
  import gate_2_pkg::*;

  logic      a;
  logic      b;
  gate_vec_t z;

  modport master (output a, output b, input z);
  modport slave  (input a, input b, output z);

endinterface
`default_nettype wire

// File: rtl/gate_2_sync_bit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_bit : SYNC_STAGES-deep single-bit synchroniser, async reset |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module sync_bit
  import gate_2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("sync_bit: SYNC_STAGES must be in 1..4");
  end

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gate_2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gate_2   : synchronised two-input bank of six registered gates   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module gate_2
  import gate_2_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  gate_2_if.slave  bus
);

  logic      a_s;
  logic      b_s;
  gate_vec_t z_d;
  gate_vec_t z_q;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.a),
    .q_o   (a_s)
  );

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.b),
    .q_o   (b_s)
  );

  always_comb begin
    z_d         = '0;
    z_d[Z_AND]  = a_s & b_s;
    z_d[Z_NAND] = ~(a_s & b_s);
    z_d[Z_OR]   = a_s | b_s;
    z_d[Z_NOR]  = ~(a_s | b_s);
    z_d[Z_XOR]  = a_s ^ b_s;
    z_d[Z_XNOR] = ~(a_s ^ b_s);
  end

  // Output register keeps z glitch-free and breaks any path from a/b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= Z_RESET;
    end else begin
      z_q <= z_d;
    end
  end

  assign bus.z = z_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gate_2 : directed self-checking bench, depths 2 and 3         |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
module tb_gate_2;
  import gate_2_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  gate_2_if bus2 ();
  gate_2_if bus3 ();

  gate_2 #(.SYNC_STAGES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  gate_2 #(.SYNC_STAGES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b);
    bus2.a = a; bus2.b = b;
    bus3.a = a; bus3.b = b;
  endtask

  // Advance to 1 time unit after the next rising edge; check complement pairs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      check("inv_d2", {3'b000, bus2.z[Z_NAND], bus2.z[Z_NOR], bus2.z[Z_XNOR]},
                      {3'b000, ~bus2.z[Z_AND], ~bus2.z[Z_OR], ~bus2.z[Z_XOR]});
      check("inv_d3", {3'b000, bus3.z[Z_NAND], bus3.z[Z_NOR], bus3.z[Z_XNOR]},
                      {3'b000, ~bus3.z[Z_AND], ~bus3.z[Z_OR], ~bus3.z[Z_XOR]});
    end
  endtask

  // Inputs are stable before edge k=1; a depth-S bank shows the new row from edge k=S+1.
  task automatic run_row(input string tag, input gate_vec_t prev_z,
                         input gate_vec_t new_z, input int hold);
    for (int k = 1; k <= hold; k++) begin
      tick();
      check($sformatf("%s_d2_k%0d", tag, k), bus2.z, (k > 2) ? new_z : prev_z);
      check($sformatf("%s_d3_k%0d", tag, k), bus3.z, (k > 3) ? new_z : prev_z);
    end
  endtask

  typedef struct packed {
    logic      a;
    logic      b;
    gate_vec_t z;
  } row_t;

  row_t rows [8];

  initial begin
    rows[0] = '{a: 1'b0, b: 1'b0, z: 6'h2A};
    rows[1] = '{a: 1'b0, b: 1'b1, z: 6'h16};
    rows[2] = '{a: 1'b1, b: 1'b0, z: 6'h16};
    rows[3] = '{a: 1'b1, b: 1'b1, z: 6'h25};
    rows[4] = '{a: 1'b0, b: 1'b0, z: 6'h2A};
    rows[5] = '{a: 1'b1, b: 1'b1, z: 6'h25};
    rows[6] = '{a: 1'b0, b: 1'b1, z: 6'h16};
    rows[7] = '{a: 1'b1, b: 1'b1, z: 6'h25};

    // Reset held with both inputs high.
    drive(1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_pre_edge_d2", bus2.z, 6'h2A);
    check("rst_pre_edge_d3", bus3.z, 6'h2A);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("rst_hold_d2_c%0d", c), bus2.z, 6'h2A);
      check($sformatf("rst_hold_d3_c%0d", c), bus3.z, 6'h2A);
    end

    // Release mid-cycle; the next rising edge is the first sampling edge.
    drive(1'b0, 1'b0);
    rst_n = 1'b1;

    // Sweep, simultaneous 00->11, and a-only step 01->11.
    begin
      gate_vec_t prev_z;
      prev_z = 6'h2A;
      for (int r = 0; r < 8; r++) begin
        drive(rows[r].a, rows[r].b);
        run_row($sformatf("row%0d", r), prev_z, rows[r].z, 20);
        prev_z = rows[r].z;
      end
    end

    // Half-cycle reset pulse while z = 25, clear of any rising edge.
    #1 rst_n = 1'b0;
    #1;
    check("midrst_async_d2", bus2.z, 6'h2A);
    check("midrst_async_d3", bus3.z, 6'h2A);
    #4 rst_n = 1'b1;
    run_row("midrst_recover", 6'h2A, 6'h25, 6);

    // Sub-period pulse on a between edges must not reach z.
    drive(1'b0, 1'b1);
    run_row("pre_glitch", 6'h25, 6'h16, 8);
    #2 bus2.a = 1'b1; bus3.a = 1'b1;
    #3 bus2.a = 1'b0; bus3.a = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("glitch_d2_c%0d", c), bus2.z, 6'h16);
      check($sformatf("glitch_d3_c%0d", c), bus3.z, 6'h16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
